fb_scanout: RTL and testbench

Display scan-out stage downstream of the frame-buffer writer. Reads the 320x240, 24-bit frame buffer (addresses 0–76799, row-major) through its read port. Pixel-doubles each entry to 640x480 and emits VGA-style RGB with sync and blank. Issues a one-clock `vblank_start` pulse each frame so the controller can start the map/sprite redraw during vertical blanking.

---
 rtl/fb_scanout.sv | 171 +++++++++++++++++
 tb/tb_fb_scanout.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// Pixel-doubling VGA scan-out from a 320x240x24 frame buffer with sync, blank and vblank_start.
// Optional `FB_SCANOUT_BORDER_EN draws a white one-pixel frame around the active area.
module fb_scanout #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [16:0] fb_rd_addr,
    input  logic [23:0] fb_rd_data,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        vblank_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  V_ACT_M1 = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [16:0] STRIDE   = 17'(H_ACTIVE / 2);
`ifdef FB_SCANOUT_BORDER_EN
    localparam logic [9:0]  H_ACT_M1 = 10'(H_ACTIVE - 1);
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       hcount_q, hcount_d;
    logic [9:0]       vcount_q, vcount_d;
    logic [16:0]      row_base_q, row_base_d;
    logic [23:0]      rgb_q, rgb_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             blank_q, blank_d;
    logic             vblank_q, vblank_d;

    logic tick;
    logic pix_active;
    logic [23:0] pix_colour;

    assign tick       = (div_q == DIV_LAST);
    assign pix_active = (hcount_q < H_ACT) && (vcount_q < V_ACT);

`ifdef FB_SCANOUT_BORDER_EN
    assign pix_colour = (hcount_q == 10'd0 || hcount_q == H_ACT_M1 ||
                         vcount_q == 10'd0 || vcount_q == V_ACT_M1) ? 24'hFFFFFF : fb_rd_data;
`else
    assign pix_colour = fb_rd_data;
`endif

    // Halving hcount repeats each address for two pixels; row_base only steps after odd lines.
    assign fb_rd_addr = pix_active ? (row_base_q + 17'(hcount_q[9:1])) : row_base_q;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        hcount_d   = hcount_q;
        vcount_d   = vcount_q;
        row_base_d = row_base_q;
        rgb_d      = rgb_q;
        hsync_d    = hsync_q;
        vsync_d    = vsync_q;
        blank_d    = blank_q;
        vblank_d   = 1'b0;
        case (state_q)
            IDLE: begin
                hcount_d   = '0;
                vcount_d   = '0;
                row_base_d = '0;
                rgb_d      = '0;
                hsync_d    = 1'b1;
                vsync_d    = 1'b1;
                blank_d    = 1'b1;
                if (!en) begin
                    div_d = '0;
                end else if (tick) begin
                    div_d   = '0;
                    state_d = RUN;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            RUN: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    // Data for the current counters arrived during this pixel, so the outputs trail by one pixel.
                    blank_d = !pix_active;
                    hsync_d = !(hcount_q >= HS_START && hcount_q < HS_END);
                    vsync_d = !(vcount_q >= VS_START && vcount_q < VS_END);
                    rgb_d   = pix_active ? pix_colour : 24'h0;
                    if (hcount_q == H_LAST) begin
                        hcount_d = '0;
                        if (vcount_q == V_ACT_M1)
                            vblank_d = 1'b1;
                        if (vcount_q == V_LAST) begin
                            vcount_d   = '0;
                            row_base_d = '0;
                            if (!en)
                                state_d = IDLE;
                        end else begin
                            vcount_d = vcount_q + 10'd1;
                            if (vcount_q[0] && vcount_q < V_ACT_M1)
                                row_base_d = row_base_q + STRIDE;
                        end
                    end else begin
                        hcount_d = hcount_q + 10'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            hcount_q   <= '0;
            vcount_q   <= '0;
            row_base_q <= '0;
            rgb_q      <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            blank_q    <= 1'b1;
            vblank_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            hcount_q   <= hcount_d;
            vcount_q   <= vcount_d;
            row_base_q <= row_base_d;
            rgb_q      <= rgb_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            blank_q    <= blank_d;
            vblank_q   <= vblank_d;
        end
    end

    assign r            = rgb_q[23:16];
    assign g            = rgb_q[15:8];
    assign b            = rgb_q[7:0];
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign blank        = blank_q;
    assign vblank_start = vblank_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Self-checking bench for fb_scanout using a shrunken raster so whole frames fit in a short run.
// Compile with +define+FB_SCANOUT_BORDER_EN to exercise the border option.
module tb_fb_scanout;

    localparam int D      = 2;
    localparam int HA     = 16;
    localparam int HFP    = 2;
    localparam int HS     = 3;
    localparam int HBP    = 3;
    localparam int VA     = 8;
    localparam int VFP    = 1;
    localparam int VS     = 2;
    localparam int VBP    = 1;
    localparam int HT     = HA + HFP + HS + HBP;
    localparam int VT     = VA + VFP + VS + VBP;
    localparam int FRAME  = HT * VT * D;
    localparam int STRIDE = HA / 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic [16:0] fbRdAddr;
    logic [23:0] fbRdData = '0;
    logic [7:0]  r, g, b;
    logic        hsync, vsync, blank, vblankStart;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int enCyc = 0;
    int memMode = 0;
    logic [31:0] memSeedA = 32'h9E3779B1;
    logic [31:0] memSeedB = 32'h0;
    logic checking = 1'b0;

    fb_scanout #(
        .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .fb_rd_addr(fbRdAddr), .fb_rd_data(fbRdData),
        .r(r), .g(g), .b(b),
        .hsync(hsync), .vsync(vsync), .blank(blank), .vblank_start(vblankStart)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] memWord(input logic [16:0] a);
        logic [31:0] t;
        if (memMode == 0) return {7'b0, a};
        if (memMode == 2) return 24'h0;
        t = ({15'b0, a} * memSeedA) ^ memSeedB;
        return t[23:0];
    endfunction

    always @(posedge clk) fbRdData <= memWord(fbRdAddr);

    function automatic int addrOf(input int h, input int v);
        int rb;
        rb = ((v / 2 < VA / 2 - 1) ? v / 2 : VA / 2 - 1) * STRIDE;
        return (h < HA && v < VA) ? rb + h / 2 : rb;
    endfunction

    function automatic logic [23:0] pixelColour(input int h, input int v);
`ifdef FB_SCANOUT_BORDER_EN
        if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) return 24'hFFFFFF;
`endif
        return memWord(17'(addrOf(h, v)));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    // Reference model: whether scanning and how many clocks into the current frame.
    logic mRun = 1'b0;
    int   mK = 0;
    int   mIdleCnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mRun <= 1'b0; mK <= 0; mIdleCnt <= 0;
        end else if (!mRun) begin
            if (!en) mIdleCnt <= 0;
            else if (mIdleCnt == D - 1) begin mRun <= 1'b1; mK <= 0; mIdleCnt <= 0; end
            else mIdleCnt <= mIdleCnt + 1;
        end else if (mK == FRAME - 1) begin
            mK <= 0;
            if (!en) mRun <= 1'b0;
        end else begin
            mK <= mK + 1;
        end
    end

    always @(negedge clk) begin
        int p, q, ph, pv;
        logic act;
        logic [16:0] eAddr;
        logic [23:0] eRgb;
        logic eBlank, eHs, eVs, eVb;
        if (checking && !rst) begin
            if (!mRun) begin
                eAddr = '0; eRgb = '0; eBlank = 1'b1; eHs = 1'b1; eVs = 1'b1; eVb = 1'b0;
            end else begin
                p     = mK / D;
                eAddr = 17'(addrOf(p % HT, p / HT));
                q     = (p == 0) ? HT * VT - 1 : p - 1;
                ph    = q % HT;
                pv    = q / HT;
                act   = (ph < HA) && (pv < VA);
                eBlank = !act;
                eHs   = !(ph >= HA + HFP && ph < HA + HFP + HS);
                eVs   = !(pv >= VA + VFP && pv < VA + VFP + VS);
                eRgb  = act ? pixelColour(ph, pv) : 24'h0;
                eVb   = (mK == VA * HT * D);
            end
            checkOutput("fb_rd_addr", 32'(fbRdAddr), 32'(eAddr));
            checkOutput("rgb", 32'({r, g, b}), 32'(eRgb));
            checkOutput("blank", 32'(blank), 32'(eBlank));
            checkOutput("hsync", 32'(hsync), 32'(eHs));
            checkOutput("vsync", 32'(vsync), 32'(eVs));
            checkOutput("vblank_start", 32'(vblankStart), 32'(eVb));
        end
    end

    int vbSeen = 0;
    always @(negedge clk) if (vblankStart) vbSeen++;

    task automatic waitCyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    function automatic int pixCyc(input int h, input int v, input int frame);
        return enCyc + D + frame * FRAME + (v * HT + h) * D;
    endfunction

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_addr"}, 32'(fbRdAddr), 32'd0);
        checkOutput({tag, "_rgb"}, 32'({r, g, b}), 32'd0);
        checkOutput({tag, "_blank"}, 32'(blank), 32'd1);
        checkOutput({tag, "_hsync"}, 32'(hsync), 32'd1);
        checkOutput({tag, "_vsync"}, 32'(vsync), 32'd1);
        checkOutput({tag, "_vblank"}, 32'(vblankStart), 32'd0);
    endtask

    task automatic measureFrame();
        int hsLow = 0, hsFalls = 0, run = 0, runMin = 1 << 30, runMax = 0;
        int perMin = 1 << 30, perMax = 0, lastFall = -1, vsLow = 0, blankLow = 0, vbCnt = 0;
        logic prevHs, inRun;
        prevHs = hsync;
        inRun = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (!hsync) begin
                hsLow++;
                if (prevHs) begin
                    hsFalls++;
                    if (lastFall >= 0) begin
                        if (i - lastFall < perMin) perMin = i - lastFall;
                        if (i - lastFall > perMax) perMax = i - lastFall;
                    end
                    lastFall = i;
                    inRun = 1'b1;
                    run = 0;
                end
                run++;
            end else if (!prevHs && inRun) begin
                if (run < runMin) runMin = run;
                if (run > runMax) runMax = run;
                inRun = 1'b0;
            end
            if (!vsync) vsLow++;
            if (!blank) blankLow++;
            if (vblankStart) vbCnt++;
            prevHs = hsync;
        end
        checkOutput("hsync_low_min", 32'(runMin), 32'd6);
        checkOutput("hsync_low_max", 32'(runMax), 32'd6);
        checkOutput("hsync_period_min", 32'(perMin), 32'd48);
        checkOutput("hsync_period_max", 32'(perMax), 32'd48);
        checkOutput("hsync_falls", 32'(hsFalls), 32'(VT));
        checkOutput("hsync_low_total", 32'(hsLow), 32'(HS * D * VT));
        checkOutput("vsync_low_total", 32'(vsLow), 32'd96);
        checkOutput("blank_low_total", 32'(blankLow), 32'(HA * D * VA));
        checkOutput("vblank_per_frame", 32'(vbCnt), 32'd1);
    endtask

    // One random slice: toggle en for a random span, occasionally hitting an async reset.
    task automatic applyStimulus();
        @(negedge clk);
        en = 1'($urandom_range(0, 3) != 0);
        repeat ($urandom_range(1, 2 * FRAME)) @(negedge clk);
        if ($urandom_range(0, 4) == 0) begin
            #2 rst = 1'b1;
            #1 checkResetOutputs("async_rst");
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    initial begin
        #2 rst = 1'b1;
        #1 checkResetOutputs("reset");
        @(negedge clk);
        rst = 1'b0;
        checking = 1'b1;
        repeat (10000) @(negedge clk);
        checkOutput("idle_vblank_count", 32'(vbSeen), 32'd0);

        en = 1'b1;
        enCyc = cyc;
        waitCyc(pixCyc(2, 0, 0));
        checkOutput("addr_h2_v0", 32'(fbRdAddr), 32'd1);
        waitCyc(pixCyc(2, 2, 0));
        checkOutput("addr_h2_v2", 32'(fbRdAddr), 32'd9);
        waitCyc(pixCyc(3, 2, 0));
        checkOutput("rgb_hold_first", 32'({r, g, b}), 32'd9);
        waitCyc(pixCyc(4, 2, 0) + D - 1);
        checkOutput("rgb_hold_last", 32'({r, g, b}), 32'd9);
        waitCyc(pixCyc(5, 2, 0));
        checkOutput("rgb_next_addr", 32'({r, g, b}), 32'd10);
        waitCyc(pixCyc(HA - 1, VA - 1, 0));
        checkOutput("addr_last_pixel", 32'(fbRdAddr), 32'(HA / 2 * VA / 2 - 1));

        waitCyc(pixCyc(0, 0, 1));
        measureFrame();

        waitCyc(pixCyc(0, 5, 2));
        en = 1'b0;
        waitCyc(pixCyc(HT - 1, VT - 1, 2));
        checkOutput("drop_en_still_running", 32'(blank), 32'd1);
        waitCyc(pixCyc(0, 0, 3) + 3);
        checkResetOutputs("after_drop");
        repeat (50) @(negedge clk);
        en = 1'b1;
        enCyc = cyc;
        waitCyc(pixCyc(0, 0, 0));
        checkOutput("restart_addr0", 32'(fbRdAddr), 32'd0);
        waitCyc(pixCyc(2, 0, 0));
        checkOutput("restart_addr1", 32'(fbRdAddr), 32'd1);
        en = 1'b0;
        waitCyc(cyc + FRAME + 2 * D);

        memMode = 1;
        memSeedA = $urandom() | 32'h1;
        memSeedB = $urandom();
        for (int i = 0; i < 20; i++) applyStimulus();

        @(negedge clk);
        en = 1'b0;
        waitCyc(cyc + FRAME + 2 * D);
`ifdef FB_SCANOUT_BORDER_EN
        memMode = 2;
        en = 1'b1;
        enCyc = cyc;
        waitCyc(pixCyc(1, 0, 0));
        checkOutput("border_row0", 32'({r, g, b}), 32'hFFFFFF);
        waitCyc(pixCyc(6, 3, 0));
        checkOutput("border_interior", 32'({r, g, b}), 32'h0);
        waitCyc(pixCyc(HA, 3, 0));
        checkOutput("border_col_last", 32'({r, g, b}), 32'hFFFFFF);
        waitCyc(pixCyc(1, 3, 0));
        waitCyc(pixCyc(6, VA - 1, 0));
        checkOutput("border_row_last", 32'({r, g, b}), 32'hFFFFFF);
        waitCyc(pixCyc(0, 0, 1) + 4);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
